// File: rtl/wb_regfile.sv
// Write-back stage merged with the general-purpose register file: WB mux, register array, two read ports, retire counter.
// Optional macro REGFILE_BYPASS_EN selects write-first reads; left undefined, the read ports are read-first.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEMWB_RegWrite_out,
  input  logic              MEMWB_MemtoReg_out,
  input  logic              MEMWB_Write_out,
  input  logic [DATA_W-1:0] MEMWB_Readata_out,
  input  logic [DATA_W-1:0] MEMWB_ALUresult_out,
  input  logic [ADDR_W-1:0] MEMWB_destination_out,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_commit,
  output logic [ADDR_W-1:0] wb_commit_addr,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regFile_q [NREGS];
  logic              wbCommit_q, wbCommit_d;
  logic [ADDR_W-1:0] commitAddr_q, commitAddr_d;
  logic [CNT_W-1:0]  retireCnt_q, retireCnt_d;
  logic              writeEn;
  logic              retireEn;

  // Register 0 is hardwired to zero, so writes aimed at it never commit.
  always_comb begin
    wb_data  = MEMWB_MemtoReg_out ? MEMWB_Readata_out : MEMWB_ALUresult_out;
    writeEn  = wb_valid & MEMWB_RegWrite_out & (MEMWB_destination_out != '0);
    retireEn = wb_valid & (MEMWB_RegWrite_out | MEMWB_Write_out |
                           ~(MEMWB_RegWrite_out | MEMWB_Write_out));
  end

  always_comb begin
    wbCommit_d   = writeEn;
    commitAddr_d = writeEn ? MEMWB_destination_out : commitAddr_q;
    retireCnt_d  = retireEn ? retireCnt_q + 1'b1 : retireCnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regFile_q[i] <= '0;
      wbCommit_q   <= 1'b0;
      commitAddr_q <= '0;
      retireCnt_q  <= '0;
    end else begin
      if (writeEn) regFile_q[MEMWB_destination_out] <= wb_data;
      wbCommit_q   <= wbCommit_d;
      commitAddr_q <= commitAddr_d;
      retireCnt_q  <= retireCnt_d;
    end
  end

  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : regFile_q[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : regFile_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
    // Write-first: the value being committed this cycle is forwarded straight to ID.
    if (writeEn && (rs_addr == MEMWB_destination_out)) rs_data = wb_data;
    if (writeEn && (rt_addr == MEMWB_destination_out)) rt_data = wb_data;
`endif
  end

  assign wb_commit      = wbCommit_q;
  assign wb_commit_addr = commitAddr_q;
  assign retire_cnt     = retireCnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps, reference model feeding an expectation queue.
// A second instance with CNT_W=4 shares all inputs to exercise retire counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWrite, memToReg, memWrite, valid;
  logic [31:0] readData, aluResult;
  logic [4:0]  dest, rsAddr, rtAddr;

  logic [31:0] rsData, rtData, wbData, retireCnt;
  logic        wbCommit;
  logic [4:0]  commitAddr;

  logic [31:0] rsData4, rtData4, wbData4;
  logic        wbCommit4;
  logic [4:0]  commitAddr4;
  logic [3:0]  retireCnt4;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .MEMWB_RegWrite_out(regWrite), .MEMWB_MemtoReg_out(memToReg),
    .MEMWB_Write_out(memWrite), .MEMWB_Readata_out(readData),
    .MEMWB_ALUresult_out(aluResult), .MEMWB_destination_out(dest),
    .wb_valid(valid), .rs_addr(rsAddr), .rt_addr(rtAddr),
    .rs_data(rsData), .rt_data(rtData), .wb_data(wbData),
    .wb_commit(wbCommit), .wb_commit_addr(commitAddr), .retire_cnt(retireCnt)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .MEMWB_RegWrite_out(regWrite), .MEMWB_MemtoReg_out(memToReg),
    .MEMWB_Write_out(memWrite), .MEMWB_Readata_out(readData),
    .MEMWB_ALUresult_out(aluResult), .MEMWB_destination_out(dest),
    .wb_valid(valid), .rs_addr(rsAddr), .rt_addr(rtAddr),
    .rs_data(rsData4), .rt_data(rtData4), .wb_data(wbData4),
    .wb_commit(wbCommit4), .wb_commit_addr(commitAddr4), .retire_cnt(retireCnt4)
  );

  typedef enum int {K_RS, K_RT, K_WB, K_COMMIT, K_CADDR, K_RETIRE, K_RETIRE4} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;

  logic [31:0] modelRegs [32];
  logic        modelCommit;
  logic [4:0]  modelCaddr;
  logic [31:0] modelCnt;

  // Reference behaviour: reads honour the bypass mode the RTL is built with.
  function automatic logic [31:0] modelRead(input logic [4:0] a);
    logic [31:0] wv;
    logic        weNow;
    wv    = memToReg ? readData : aluResult;
    weNow = valid && regWrite && (dest != 5'd0);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (weNow && (a == dest)) return wv;
`endif
    return modelRegs[a];
  endfunction

  task automatic pushExp(input string tag, input kind_t kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sbq.push_back(e);
  endtask

  task automatic pushModel(input string tag);
    pushExp({tag, ".rs"},      K_RS,      modelRead(rsAddr));
    pushExp({tag, ".rt"},      K_RT,      modelRead(rtAddr));
    pushExp({tag, ".wb"},      K_WB,      memToReg ? readData : aluResult);
    pushExp({tag, ".commit"},  K_COMMIT,  {31'd0, modelCommit});
    pushExp({tag, ".caddr"},   K_CADDR,   {27'd0, modelCaddr});
    pushExp({tag, ".retire"},  K_RETIRE,  modelCnt);
    pushExp({tag, ".retire4"}, K_RETIRE4, {28'd0, modelCnt[3:0]});
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        K_RS:      obs = rsData;
        K_RT:      obs = rtData;
        K_WB:      obs = wbData;
        K_COMMIT:  obs = {31'd0, wbCommit};
        K_CADDR:   obs = {27'd0, commitAddr};
        K_RETIRE:  obs = retireCnt;
        default:   obs = {28'd0, retireCnt4};
      endcase
      total++;
      assert (obs === e.exp)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic rw, input logic m2r,
                               input logic w, input logic [31:0] rd, input logic [31:0] alu,
                               input logic [4:0] d, input logic [4:0] ra, input logic [4:0] rb);
    rst = r; valid = v; regWrite = rw; memToReg = m2r; memWrite = w;
    readData = rd; aluResult = alu; dest = d; rsAddr = ra; rtAddr = rb;
    #1;
  endtask

  // Advance one edge and update the model the way the hardware should.
  task automatic tick();
    logic        weNow;
    logic [31:0] wv;
    weNow = valid && regWrite && (dest != 5'd0);
    wv    = memToReg ? readData : aluResult;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
      modelCommit = 1'b0;
      modelCaddr  = 5'd0;
      modelCnt    = 32'd0;
    end else begin
      if (weNow) begin
        modelRegs[dest] = wv;
        modelCaddr      = dest;
      end
      modelCommit = weNow;
      if (valid) modelCnt = modelCnt + 32'd1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    modelCommit = 1'b0;
    modelCaddr  = 5'd0;
    modelCnt    = 32'd0;

    $display("[TB] reset then read");
    applyStimulus(1, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
    pushExp("rst.rs5", K_RS, 32'd0);
    pushExp("rst.rt31", K_RT, 32'd0);
    pushExp("rst.retire", K_RETIRE, 32'd0);
    pushExp("rst.commit", K_COMMIT, 32'd0);
    pushModel("rst");
    checkOutput();
    tick();

    $display("[TB] ALU write-back to r8");
    applyStimulus(0, 1, 1, 0, 0, 32'hFFFF_0000, 32'h0000_1234, 5'd8, 5'd8, 5'd0);
    pushExp("alu.wbdata", K_WB, 32'h0000_1234);
    pushModel("alu");
    checkOutput();
    tick();

    $display("[TB] load write to r9");
    applyStimulus(0, 1, 1, 1, 0, 32'hDEAD_BEEF, 32'h0000_0042, 5'd9, 5'd8, 5'd9);
    pushExp("alu.rs8", K_RS, 32'h0000_1234);
    pushExp("alu.commit", K_COMMIT, 32'd1);
    pushExp("alu.caddr", K_CADDR, 32'd8);
    pushExp("alu.retire", K_RETIRE, 32'd1);
    pushExp("load.wbdata", K_WB, 32'hDEAD_BEEF);
    pushModel("load");
    checkOutput();
    tick();

    $display("[TB] load aimed at r0");
    applyStimulus(0, 1, 1, 1, 0, 32'hCAFE_F00D, 32'd0, 5'd0, 5'd9, 5'd0);
    pushExp("load.rs9", K_RS, 32'hDEAD_BEEF);
    pushExp("load.caddr", K_CADDR, 32'd9);
    pushModel("r0wr");
    checkOutput();
    tick();

    $display("[TB] bubble with RegWrite set");
    applyStimulus(0, 0, 1, 0, 0, 32'd0, 32'd7, 5'd10, 5'd0, 5'd10);
    pushExp("r0wr.rs0", K_RS, 32'd0);
    pushExp("r0wr.commit", K_COMMIT, 32'd0);
    pushExp("r0wr.caddr", K_CADDR, 32'd9);
    pushExp("r0wr.retire", K_RETIRE, 32'd3);
    pushModel("bubble");
    checkOutput();
    tick();

    $display("[TB] store retires without writing");
    applyStimulus(0, 1, 0, 0, 1, 32'd0, 32'd7, 5'd10, 5'd10, 5'd9);
    pushExp("bubble.rt10", K_RS, 32'd0);
    pushExp("bubble.retire", K_RETIRE, 32'd3);
    pushModel("store");
    checkOutput();
    tick();

    $display("[TB] same-cycle read of r3");
    applyStimulus(0, 1, 1, 0, 0, 32'd0, 32'h11, 5'd3, 5'd10, 5'd3);
    pushExp("store.rs10", K_RS, 32'd0);
    pushExp("store.retire", K_RETIRE, 32'd4);
    pushExp("store.commit", K_COMMIT, 32'd0);
    pushModel("pre3");
    checkOutput();
    tick();
    applyStimulus(0, 1, 1, 0, 0, 32'd0, 32'h22, 5'd3, 5'd3, 5'd3);
`ifdef REGFILE_BYPASS_EN
    pushExp("byp.rs3", K_RS, 32'h22);
    pushExp("byp.rt3", K_RT, 32'h22);
`else
    pushExp("byp.rs3", K_RS, 32'h11);
    pushExp("byp.rt3", K_RT, 32'h11);
`endif
    pushModel("byp");
    checkOutput();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd3);
    pushExp("post.rs3", K_RS, 32'h22);
    pushExp("post.rt3", K_RT, 32'h22);
    pushExp("post.caddr", K_CADDR, 32'd3);
    pushModel("post");
    checkOutput();
    tick();

    $display("[TB] reset collides with write to r4");
    applyStimulus(1, 1, 1, 0, 0, 32'd0, 32'h55, 5'd4, 5'd4, 5'd3);
    pushModel("rstwr");
    checkOutput();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd4, 5'd3);
    pushExp("rstwr.rs4", K_RS, 32'd0);
    pushExp("rstwr.rt3", K_RT, 32'd0);
    pushExp("rstwr.retire", K_RETIRE, 32'd0);
    pushExp("rstwr.commit", K_COMMIT, 32'd0);
    pushExp("rstwr.caddr", K_CADDR, 32'd0);
    pushModel("rstwr2");
    checkOutput();

    $display("[TB] sixteen retires with assorted writes");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 1'(i % 3 != 2), 1'(i % 2), 1'(i % 3 == 2), $urandom, $urandom,
                    5'(i + 1), 5'(i), 5'(i + 1));
      pushModel($sformatf("wrap%0d", i));
      checkOutput();
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd16, 5'd15);
    pushExp("wrap.retire4", K_RETIRE4, 32'd0);
    pushExp("wrap.retire", K_RETIRE, 32'd16);
    pushModel("wrapend");
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
